// File: rtl/accum_pkg.sv
// Shared types and lane arithmetic for the accumulator bank responder.
// Optional feature macro: ACCUM_SAT_EN selects saturating lane adds instead of wrap.
package accum_pkg;
  localparam int DEF_NUM_BANKS  = 4;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_LANE_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_ZONE_WIDTH = 2;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0]                    addr;
    logic [DEF_ZONE_WIDTH-1:0]                    zone;
    logic [DEF_NUM_BANKS-1:0]                     mask;
    logic                                         accum_en;
    logic [DEF_NUM_BANKS-1:0][DEF_DATA_WIDTH-1:0] data;
  } s1_entry_t;

  function automatic logic [DEF_LANE_WIDTH-1:0] lane_add(
    input logic [DEF_LANE_WIDTH-1:0] a,
    input logic [DEF_LANE_WIDTH-1:0] b
  );
`ifdef ACCUM_SAT_EN
    logic [DEF_LANE_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DEF_LANE_WIDTH] ? '1 : sum[DEF_LANE_WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction
endpackage

// File: rtl/accum_sram_1r1w.sv
// One accumulator bank: behavioural 1R1W array, synchronous read, read-during-write returns old data.
module accum_sram_1r1w
  import accum_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH + DEF_ZONE_WIDTH
) (
  input  logic                  clk,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/accum_bank_responder.sv
// Accumulator-bus responder: banked SRAM, 2-stage accumulate RMW with forwarding, RAW read bypass.
// Optional feature macro: ACCUM_SAT_EN (saturating lanes, see accum_pkg::lane_add).
module accum_bank_responder
  import accum_pkg::*;
#(
  parameter int NUM_BANKS  = DEF_NUM_BANKS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANE_WIDTH = DEF_LANE_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZONE_WIDTH = DEF_ZONE_WIDTH
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            wr_valid,
  input  logic                            accum_en,
  input  logic [NUM_BANKS-1:0]            wr_mask,
  input  logic [ADDR_WIDTH-1:0]           wr_addr,
  input  logic [ZONE_WIDTH-1:0]           wr_zone_id,
  input  logic                            wvalid,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] wdata,
  input  logic                            rd_valid,
  input  logic [NUM_BANKS-1:0]            rd_mask,
  input  logic [ADDR_WIDTH-1:0]           rd_addr,
  input  logic [ZONE_WIDTH-1:0]           rd_zone_id,
  output logic                            rd_ready,
  output logic                            rvalid,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] rdata
);
  localparam int PA_W  = ZONE_WIDTH + ADDR_WIDTH;
  localparam int LANES = DATA_WIDTH / LANE_WIDTH;

  typedef logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_data_t;

  logic                 wr_acc, acc_rd, rd_acc;
  s1_entry_t            s1;
  logic                 s1_valid, fwd_valid;
  logic [PA_W-1:0]      s1_pa, fwd_pa, sram_raddr;
  logic [NUM_BANKS-1:0] fwd_mask, fwd_hit, byp_hit, byp_hit_q, rd_mask_q, sram_we;
  bank_data_t           sram_q, old, s1_res, fwd_data, byp_data_q;

  assign wr_acc     = wr_valid && wvalid;
  assign acc_rd     = wr_acc && accum_en;
  assign rd_ready   = !acc_rd;
  assign rd_acc     = rd_valid && rd_ready;
  assign s1_pa      = {s1.zone, s1.addr};
  // The accumulate owns the read port; its old value lands in sram_q one cycle later.
  assign sram_raddr = acc_rd ? {wr_zone_id, wr_addr} : {rd_zone_id, rd_addr};

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    // Previous result is written at the same edge the SRAM read sampled, so the read saw stale data.
    assign fwd_hit[b] = fwd_valid && fwd_mask[b] && (fwd_pa == s1_pa);
    assign byp_hit[b] = s1_valid && s1.mask[b] && (s1_pa == {rd_zone_id, rd_addr});
    assign sram_we[b] = s1_valid && s1.mask[b];
    assign old[b]     = fwd_hit[b] ? fwd_data[b] : sram_q[b];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign s1_res[b][l*LANE_WIDTH +: LANE_WIDTH] = s1.accum_en ?
        lane_add(old[b][l*LANE_WIDTH +: LANE_WIDTH], s1.data[b][l*LANE_WIDTH +: LANE_WIDTH]) :
        s1.data[b][l*LANE_WIDTH +: LANE_WIDTH];
    end

    accum_sram_1r1w #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(PA_W)) u_sram (
      .clk   (clk),
      .re    (acc_rd || rd_acc),
      .raddr (sram_raddr),
      .rdata (sram_q[b]),
      .we    (sram_we[b]),
      .waddr (s1_pa),
      .wdata (s1_res[b])
    );

    assign rdata[b*DATA_WIDTH +: DATA_WIDTH] = (rvalid && rd_mask_q[b]) ?
      (byp_hit_q[b] ? byp_data_q[b] : sram_q[b]) : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      fwd_valid <= 1'b0;
      rvalid    <= 1'b0;
    end else begin
      s1_valid  <= wr_acc;
      fwd_valid <= s1_valid;
      rvalid    <= rd_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc)
      s1 <= '{addr: wr_addr, zone: wr_zone_id, mask: wr_mask, accum_en: accum_en, data: wdata};
    if (s1_valid) begin
      fwd_pa   <= s1_pa;
      fwd_mask <= s1.mask;
      fwd_data <= s1_res;
    end
    if (rd_acc) begin
      rd_mask_q  <= rd_mask;
      byp_hit_q  <= byp_hit;
      byp_data_q <= s1_res;
    end
  end

  // Bus contract: a read is never presented while an accumulate holds the port.
  always_ff @(posedge clk) begin
    if (rstn) assert (!(rd_valid && !rd_ready));
  end
endmodule

// File: tb/tb_accum_bank_responder.sv
// Directed + random bench for accum_bank_responder against a flat memory reference model.
module tb_accum_bank_responder;
  localparam int NB = 4, DW = 64, AW = 9, ZW = 2, BW = NB * DW;

  logic          clk = 1'b0, rstn = 1'b1;
  logic          wr_valid = 0, accum_en = 0, wvalid = 0, rd_valid = 0;
  logic [NB-1:0] wr_mask = '0, rd_mask = '0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [ZW-1:0] wr_zone_id = '0, rd_zone_id = '0;
  logic [BW-1:0] wdata = '0;
  logic          rd_ready, rvalid;
  logic [BW-1:0] rdata;

  int            total = 0, bad = 0;
  logic [BW-1:0] mem [0:2047];
  logic [BW-1:0] last_rd;

  accum_bank_responder dut (
    .clk(clk), .rstn(rstn), .wr_valid(wr_valid), .accum_en(accum_en), .wr_mask(wr_mask),
    .wr_addr(wr_addr), .wr_zone_id(wr_zone_id), .wvalid(wvalid), .wdata(wdata),
    .rd_valid(rd_valid), .rd_mask(rd_mask), .rd_addr(rd_addr), .rd_zone_id(rd_zone_id),
    .rd_ready(rd_ready), .rvalid(rvalid), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] rnd();
    logic [BW-1:0] r;
    for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: each masked bank is overwritten, or each 16-bit lane gets old+new independently.
  function automatic logic [BW-1:0] model_wr(input logic [BW-1:0] old, input logic [BW-1:0] wd,
                                             input logic acc, input logic [NB-1:0] m);
    logic [BW-1:0] r;
    int unsigned   s;
    r = old;
    for (int b = 0; b < NB; b++) begin
      if (m[b]) begin
        for (int l = 0; l < DW / 16; l++) begin
          s = 32'(old[b*DW + l*16 +: 16]) + 32'(wd[b*DW + l*16 +: 16]);
`ifdef ACCUM_SAT_EN
          if (s > 32'd65535) s = 32'd65535;
`else
          s = s % 32'd65536;
`endif
          r[b*DW + l*16 +: 16] = acc ? s[15:0] : wd[b*DW + l*16 +: 16];
        end
      end
    end
    return r;
  endfunction

  // One bus cycle: drive at negedge, check rd_ready, update model, check read result after the edge.
  task automatic cyc(input logic wv, input logic wvv, input logic acc, input logic [NB-1:0] wm,
                     input int wa, input int wz, input logic [BW-1:0] wd,
                     input logic rv, input logic [NB-1:0] rm, input int ra, input int rz);
    logic [BW-1:0] exp_rd;
    logic          exp_ready, issued;
    exp_ready = !(wv && wvv && acc);
    issued    = rv && exp_ready;
    wr_valid = wv; wvalid = wvv; accum_en = acc; wr_mask = wm;
    wr_addr = AW'(wa); wr_zone_id = ZW'(wz); wdata = wd;
    rd_valid = issued; rd_mask = rm; rd_addr = AW'(ra); rd_zone_id = ZW'(rz);
    exp_rd = '0;
    for (int b = 0; b < NB; b++)
      if (rm[b]) exp_rd[b*DW +: DW] = mem[rz*512 + ra][b*DW +: DW];
    if (wv && wvv) mem[wz*512 + wa] = model_wr(mem[wz*512 + wa], wd, acc, wm);
    #1 chk("rd_ready", BW'(rd_ready), BW'(exp_ready));
    @(posedge clk);
    #1 chk("rvalid", BW'(rvalid), BW'(issued));
    if (issued) chk("rdata", rdata, exp_rd);
    last_rd = rdata;
    @(negedge clk);
  endtask

  task automatic wr(input logic acc, input logic [NB-1:0] m, input int a, input logic [BW-1:0] d);
    cyc(1, 1, acc, m, a, 0, d, 0, '0, 0, 0);
  endtask

  task automatic rd(input int a);
    cyc(0, 0, 0, '0, 0, 0, '0, 1, 4'hF, a, 0);
  endtask

  initial begin
    logic [BW-1:0] old9, new9, exp9, old13;
    #1 rstn = 1'b0;
    #2;
    chk("reset_rvalid", BW'(rvalid), BW'(1'b0));
    chk("reset_rdata", rdata, '0);
    chk("reset_rd_ready", BW'(rd_ready), BW'(1'b1));
    @(negedge clk) rstn = 1'b1;

    for (int z = 0; z < 2; z++)
      for (int a = 0; a < 16; a++) cyc(1, 1, 0, 4'hF, a, z, rnd(), 0, '0, 0, 0);

    // plain write then read next cycle
    wr(0, 4'hF, 5, {NB{64'h1111_2222_3333_4444}});
    rd(5);
    chk("plain_rb", last_rd, {NB{64'h1111_2222_3333_4444}});

    // back-to-back accumulates forward through stage 1
    wr(0, 4'hF, 7, {(BW/16){16'h0001}});
    for (int i = 0; i < 3; i++) wr(1, 4'hF, 7, {(BW/16){16'h0002}});
    rd(7);
    chk("accum_fwd", last_rd, {(BW/16){16'h0007}});

    // lane boundary: no carry into lane 1
    wr(0, 4'hF, 11, {NB{64'h0000_0000_0000_FFFF}});
    wr(1, 4'hF, 11, {NB{64'h0000_0000_0000_0002}});
    rd(11);
`ifdef ACCUM_SAT_EN
    chk("lane_edge", last_rd, {NB{64'h0000_0000_0000_FFFF}});
`else
    chk("lane_edge", last_rd, {NB{64'h0000_0000_0000_0001}});
`endif

    // read held off by an accumulate, accepted next cycle
    cyc(1, 1, 1, 4'hF, 3, 0, rnd(), 1, 4'hF, 5, 0);
    rd(5);
    chk("held_read", last_rd, {NB{64'h1111_2222_3333_4444}});

    // partial-mask write then read in the stage-1 write cycle
    old9 = mem[9];
    new9 = rnd();
    for (int b = 0; b < NB; b++)
      exp9[b*DW +: DW] = (b % 2 == 0) ? new9[b*DW +: DW] : old9[b*DW +: DW];
    wr(0, 4'b0101, 9, new9);
    rd(9);
    chk("raw_mask", last_rd, exp9);

    // reset while stage 1 holds a write: write discarded, rvalid drops at once
    old13 = mem[13];
    wr_valid = 1; wvalid = 1; accum_en = 0; wr_mask = 4'hF; wr_addr = 13; wr_zone_id = 0;
    wdata = ~old13;
    rd_valid = 1; rd_mask = 4'hF; rd_addr = 5; rd_zone_id = 0;
    @(posedge clk);
    #1 chk("pre_rst_rvalid", BW'(rvalid), BW'(1'b1));
    chk("pre_rst_rdata", rdata, {NB{64'h1111_2222_3333_4444}});
    #1 rstn = 1'b0;
    wr_valid = 0; wvalid = 0; rd_valid = 0;
    #1 chk("mid_rst_rvalid", BW'(rvalid), BW'(1'b0));
    chk("mid_rst_rdata", rdata, '0);
    @(negedge clk) rstn = 1'b1;
    rd(13);
    chk("rst_discard", last_rd, old13);

    // random traffic with hot addresses so forwarding and bypass fire often
    for (int i = 0; i < 400; i++) begin
      logic wv, wvv;
      int   wa, wz, ra, rz;
      wv  = ($urandom_range(0, 3) != 0);
      wvv = ($urandom_range(0, 7) == 0) ? !wv : wv;
      wa  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
      wz  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      ra  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
      rz  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      cyc(wv, wvv, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), wa, wz, rnd(),
          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ra, rz);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
